// File: rtl/lab5_mem_pkg.sv
// Shared encodings for the lab 5 memory unit: request modes, FSM states
// and the reset-pattern multiplier.
package lab5_mem_pkg;

  typedef enum logic [1:0] {
    MODE_READ  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_CLEAR = 2'b11
  } modeT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_CLEAR = 2'b10
  } stateT;

  localparam int RESET_MULT = 3;

endpackage

// File: rtl/lab5_mem_unit_if.sv
// Request/response bundle between the request source (master) and the
// memory unit (slave).
interface lab5_mem_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5
);
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_mode;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic [DATA_W+ADDR_W-1:0] scan_sum;

  modport master (
    output req_valid, req_mode, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, scan_sum
  );

  modport slave (
    input  req_valid, req_mode, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, scan_sum
  );
endinterface

// File: rtl/lab5_seq_walker.sv
// Index counter shared by SCAN and CLEAR: restarts at 0 on start, advances
// on step, flags the last entry; wraps back to 0 after the last entry.
module lab5_seq_walker #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] index,
  output logic              last
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      index <= '0;
    end else if (start) begin
      index <= '0;
    end else if (step) begin
      index <= index + 1'b1;
    end
  end

  assign last = (index == {ADDR_W{1'b1}});

endmodule

// File: rtl/lab5_mem_unit.sv
// Clocked 2^ADDR_W x DATA_W memory with single-cycle READ/WRITE and
// multi-cycle SCAN (sum all entries) and CLEAR (zero all entries).
//
// state    | meaning
// ST_IDLE  | ready; READ/WRITE complete at the accept edge
// ST_SCAN  | walking entries into the accumulator, requests blocked
// ST_CLEAR | walking entries to zero, requests blocked
module lab5_mem_unit
  import lab5_mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 5
) (
  input logic           CLK,
  input logic           RST_N,
  lab5_mem_unit_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SUM_W = DATA_W + ADDR_W;

  stateT              state;
  stateT              stateNext;
  modeT               mode;
  logic               accept;
  logic               reqReady;
  logic               walkStart;
  logic               walkStep;
  logic [ADDR_W-1:0]  idx;
  logic               idxLast;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   accNext;
  logic               rspValid;
  logic [DATA_W-1:0]  rspRdata;
  logic [SUM_W-1:0]   scanSum;

  assign mode    = modeT'(bus.req_mode);
  assign accept  = bus.req_valid && reqReady;
  assign accNext = acc + SUM_W'(mem[idx]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        if (accept && mode == MODE_SCAN)  stateNext = ST_SCAN;
        if (accept && mode == MODE_CLEAR) stateNext = ST_CLEAR;
      end
      ST_SCAN, ST_CLEAR: begin
        if (idxLast) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state == ST_IDLE);
    walkStart = accept && (mode == MODE_SCAN || mode == MODE_CLEAR);
    walkStep  = (state != ST_IDLE);
  end

  lab5_seq_walker #(.ADDR_W(ADDR_W)) uWalker (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (walkStart),
    .step  (walkStep),
    .index (idx),
    .last  (idxLast)
  );

  // Memory reloads its pattern on every reset, including mid-operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(RESET_MULT * i);
      end
      rspValid <= 1'b0;
      rspRdata <= '0;
      scanSum  <= '0;
      acc      <= '0;
    end else begin
      rspValid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            unique case (mode)
              MODE_READ: begin
                rspRdata <= mem[bus.req_addr];
                rspValid <= 1'b1;
              end
              MODE_WRITE: begin
                mem[bus.req_addr] <= bus.req_wdata;
                rspRdata          <= bus.req_wdata;
                rspValid          <= 1'b1;
              end
              MODE_SCAN:  acc <= '0;
              default: ;
            endcase
          end
        end
        ST_SCAN: begin
          acc <= accNext;
          if (idxLast) begin
            scanSum  <= accNext;
            rspValid <= 1'b1;
          end
        end
        ST_CLEAR: begin
          mem[idx] <= '0;
          if (idxLast) rspValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspRdata;
  assign bus.scan_sum  = scanSum;

endmodule

// File: tb/tb_lab5_mem_unit.sv
// Directed bench for lab5_mem_unit: expected responses are queued at issue
// time and checked by a monitor when rsp_valid pulses.
module tb_lab5_mem_unit;
  import lab5_mem_pkg::*;

  localparam int AW = 4;
  localparam int DW = 5;

  typedef struct {
    logic [DW-1:0]    rdata;
    logic             chkRdata;
    logic [DW+AW-1:0] sum;
    logic             chkSum;
    int               due;
  } expT;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  expT  sb[$];

  lab5_mem_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lab5_mem_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a request at the current negedge, queue its expectation, advance one cycle.
  task automatic issue(input modeT m, input int addr, input int wdata, input int lat,
                       input logic chkR, input int expR, input logic chkS, input int expS);
    expT e;
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    bus.req_addr  = AW'(addr);
    bus.req_wdata = DW'(wdata);
    e.rdata = DW'(expR);
    e.chkRdata = chkR;
    e.sum = (DW+AW)'(expS);
    e.chkSum = chkS;
    e.due = cyc + lat;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RST_N && bus.rsp_valid) begin
      expT e;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_rsp: observed rsp_valid=1 at cycle %0d expected no response", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_latency", cyc, e.due);
        if (e.chkRdata) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
        if (e.chkSum)   chk("scan_sum", 32'(bus.scan_sum), 32'(e.sum));
      end
    end
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mode  = MODE_READ;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge CLK);
    chk("reset_ready", 32'(bus.req_ready), 1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_rdata", 32'(bus.rsp_rdata), 0);
    chk("reset_sum", 32'(bus.scan_sum), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reads of the reset pattern, back-to-back, then the pulse must drop.
    chk("idle_ready", 32'(bus.req_ready), 1);
    issue(MODE_READ, 0, 0, 1, 1'b1, 0, 1'b0, 0);
    issue(MODE_READ, 2, 0, 1, 1'b1, 6, 1'b0, 0);
    idle(1);
    chk("rsp_pulse_end", 32'(bus.rsp_valid), 0);
    idle(1);

    // SCAN from reset pattern: ready low 16 cycles, sum 200.
    issue(MODE_SCAN, 0, 0, 17, 1'b0, 0, 1'b1, 200);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("scan_ready_low", 32'(bus.req_ready), 0);
      @(negedge CLK);
    end
    chk("scan_ready_back", 32'(bus.req_ready), 1);
    idle(2);

    // Reset in the middle of a SCAN: aborted, outputs reset at once.
    issue(MODE_SCAN, 0, 0, 17, 1'b0, 0, 1'b1, 200);
    idle(6);
    #2 RST_N = 1'b0;
    #1;
    sb.delete();
    chk("async_ready", 32'(bus.req_ready), 1);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("async_rdata", 32'(bus.rsp_rdata), 0);
    chk("async_sum", 32'(bus.scan_sum), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(20);
    issue(MODE_READ, 2, 0, 1, 1'b1, 6, 1'b0, 0);

    // Write then read-after-write, neighbour untouched.
    issue(MODE_WRITE, 5, 21, 1, 1'b1, 21, 1'b0, 0);
    issue(MODE_READ, 5, 0, 1, 1'b1, 21, 1'b0, 0);
    issue(MODE_READ, 4, 0, 1, 1'b1, 12, 1'b0, 0);
    idle(2);

    // Requests held during SCAN are ignored; sum reflects addr 5 = 21.
    issue(MODE_SCAN, 0, 0, 17, 1'b0, 0, 1'b1, 206);
    bus.req_mode  = MODE_WRITE;
    bus.req_addr  = 4'd1;
    bus.req_wdata = 5'd31;
    repeat (15) @(negedge CLK);
    idle(3);
    issue(MODE_READ, 1, 0, 1, 1'b1, 3, 1'b0, 0);
    idle(2);

    // CLEAR keeps rsp_rdata, then SCAN sums to zero and reads return zero.
    issue(MODE_CLEAR, 0, 0, 17, 1'b1, 3, 1'b0, 0);
    idle(16);
    issue(MODE_SCAN, 0, 0, 17, 1'b0, 0, 1'b1, 0);
    idle(16);
    issue(MODE_READ, 0, 0, 1, 1'b1, 0, 1'b0, 0);
    issue(MODE_READ, 7, 0, 1, 1'b1, 0, 1'b0, 0);
    issue(MODE_READ, 15, 0, 1, 1'b1, 0, 1'b0, 0);
    idle(4);

    chk("all_responses_seen", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
